// File: rtl/multi_dataflow_mac_mdc_fsm_pkg.sv
// Shared types for the multi-dataflow MAC job sequencer.
// Contents:
//   mac_mdc_fsm_state_t - sequencer state encoding.
//   mac_mdc_ctrl_t      - start requests broadcast to sources, sink and engine.
//   mac_mdc_flags_t     - collapsed ready/done status from the streamer.
//   LenWidthDefault     - default width of the job length and beat counter.
package multi_dataflow_mac_mdc_package;

    localparam int unsigned LenWidthDefault = 16;

    typedef enum logic [2:0] {
        StIdle,
        StWaitRdy,
        StStart,
        StRun,
        StDrain,
        StDone
    } mac_mdc_fsm_state_t;

    // All sources start together, so a single bit covers every source.
    typedef struct packed {
        logic src;
        logic sink;
        logic engine;
    } mac_mdc_ctrl_t;

    typedef struct packed {
        logic src_ready;
        logic sink_ready;
        logic sink_done;
    } mac_mdc_flags_t;

    function automatic logic all_ready(mac_mdc_flags_t f);
        return f.src_ready && f.sink_ready;
    endfunction

endpackage

// File: rtl/multi_dataflow_mac_mdc_fsm_beat_cnt.sv
// Loadable output-beat counter with terminal-count compare.
// Ports:
//   clk_i  - clock;  rst_i - synchronous active-high reset (zeroes count and length)
//   load_i - latch len_i and clear the count
//   len_i  - job length to latch
//   inc_i  - count one beat
//   cnt_o  - current beat count
//   last_o - count equals latched length minus one (next beat is the final one)
module multi_dataflow_mac_mdc_beat_cnt
    import multi_dataflow_mac_mdc_package::*;
#(
    parameter int unsigned LEN_WIDTH = LenWidthDefault
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    input  logic                 inc_i,
    output logic [LEN_WIDTH-1:0] cnt_o,
    output logic                 last_o
);

    localparam logic [LEN_WIDTH-1:0] One = LEN_WIDTH'(1);

    logic [LEN_WIDTH-1:0] cnt_q;
    logic [LEN_WIDTH-1:0] len_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            len_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
            len_q <= len_i;
        end else if (inc_i) begin
            cnt_q <= cnt_q + One;
        end
    end

    // The sequencer leaves RUN on the beat that hits this compare, so the
    // count tops out at len and cannot wrap even for the all-ones length.
    assign last_o = (cnt_q == (len_q - One));
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/multi_dataflow_mac_mdc_fsm.sv
// Job sequencer for the multi-dataflow MAC HWPE.
// Latches the job length on a trigger, waits for the streamer to be ready,
// fires one start pulse to every source, the sink and the engine, counts
// output beats, waits for the sink to retire its writes and then pulses
// done/event.
// Ports:
//   clk_i, rst_i (sync active-high), clear_i (sync soft clear)
//   start_i, len_i            - job trigger and length (sampled in IDLE)
//   wdog_lim_i                - watchdog limit, 0 disables
//   src_ready_start_i, sink_ready_start_i, sink_done_i - streamer status
//   out_valid_i, out_ready_i  - observed output handshake (one beat each)
//   src_req_start_o, sink_req_start_o, engine_start_o  - start pulses
//   busy_o, done_o, evt_o, err_o, beat_cnt_o           - status
// Build option: define MULTI_DATAFLOW_MAC_MDC_FSM_WDOG_EN to include the
// RUN/DRAIN watchdog; without it err_o is tied low and wdog_lim_i is unused.
module multi_dataflow_mac_mdc_fsm
    import multi_dataflow_mac_mdc_package::*;
#(
    parameter int unsigned N_IN       = 3,
    parameter int unsigned LEN_WIDTH  = LenWidthDefault,
    parameter int unsigned WDOG_WIDTH = 20
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic [WDOG_WIDTH-1:0] wdog_lim_i,
    input  logic [N_IN-1:0]       src_ready_start_i,
    input  logic                  sink_ready_start_i,
    input  logic                  sink_done_i,
    input  logic                  out_valid_i,
    input  logic                  out_ready_i,
    output logic [N_IN-1:0]       src_req_start_o,
    output logic                  sink_req_start_o,
    output logic                  engine_start_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  evt_o,
    output logic                  err_o,
    output logic [LEN_WIDTH-1:0]  beat_cnt_o
);

    mac_mdc_fsm_state_t state_q, state_d;
    mac_mdc_ctrl_t      ctrl_q, ctrl_d;
    mac_mdc_flags_t     flags;
    logic               busy_q, done_q;
    logic               cnt_load, cnt_inc, cnt_last;
    logic               beat, wdog_hit, sync_rst;

    assign sync_rst = rst_i || clear_i;
    assign beat     = out_valid_i && out_ready_i;

    assign flags.src_ready  = &src_ready_start_i;
    assign flags.sink_ready = sink_ready_start_i;
    assign flags.sink_done  = sink_done_i;

    multi_dataflow_mac_mdc_beat_cnt #(
        .LEN_WIDTH (LEN_WIDTH)
    ) u_beat_cnt (
        .clk_i  (clk_i),
        .rst_i  (sync_rst),
        .load_i (cnt_load),
        .len_i  (len_i),
        .inc_i  (cnt_inc),
        .cnt_o  (beat_cnt_o),
        .last_o (cnt_last)
    );

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    cnt_load = 1'b1;
                    state_d  = (len_i == '0) ? StDone : StWaitRdy;
                end
            end
            StWaitRdy: if (all_ready(flags)) state_d = StStart;
            StStart:   state_d = StRun;
            StRun: begin
                if (beat) begin
                    cnt_inc = 1'b1;
                    if (cnt_last) state_d = StDrain;
                end
            end
            StDrain:   if (flags.sink_done) state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        // The watchdog overrides normal progress in the streaming states.
        if ((state_q == StRun || state_q == StDrain) && wdog_hit) begin
            state_d = StDone;
        end
        // Outputs are registered copies of the next-state decode, so they
        // line up with the state register (Moore, glitch-free).
        ctrl_d        = '0;
        ctrl_d.src    = (state_d == StStart);
        ctrl_d.sink   = (state_d == StStart);
        ctrl_d.engine = (state_d == StStart);
    end

    always_ff @(posedge clk_i) begin
        if (sync_rst) begin
            state_q <= StIdle;
            ctrl_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            busy_q  <= (state_d != StIdle);
            done_q  <= (state_d == StDone);
        end
    end

`ifdef MULTI_DATAFLOW_MAC_MDC_FSM_WDOG_EN
    localparam logic [WDOG_WIDTH-1:0] WdogOne = WDOG_WIDTH'(1);

    logic [WDOG_WIDTH-1:0] wdog_q;
    logic                  err_q;

    // Fires on the last allowed cycle so DONE follows exactly wdog_lim_i
    // cycles spent in RUN+DRAIN.
    assign wdog_hit = (wdog_lim_i != '0) && (wdog_q == (wdog_lim_i - WdogOne));

    always_ff @(posedge clk_i) begin
        if (sync_rst) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_d == StStart) begin
                wdog_q <= '0;
            end else if (state_q == StRun || state_q == StDrain) begin
                wdog_q <= wdog_q + WdogOne;
            end
            if (state_q == StIdle && start_i) begin
                err_q <= 1'b0;
            end else if ((state_q == StRun || state_q == StDrain) && wdog_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    logic unused_wdog_lim;
    assign unused_wdog_lim = ^wdog_lim_i;
    assign wdog_hit        = 1'b0;
    assign err_o           = 1'b0;
`endif

    assign src_req_start_o  = {N_IN{ctrl_q.src}};
    assign sink_req_start_o = ctrl_q.sink;
    assign engine_start_o   = ctrl_q.engine;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign evt_o            = done_q;

endmodule
